// File: rtl/memory_access_unit_pkg.sv
// Shared types for the memory access unit: FSM states, func3 codes, sizes.
package memory_access_unit_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      SIZE_BYTE,
      SIZE_HALF,
      SIZE_WORD
   } size_t;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   // Codes 011, 110 and 111 fall through to a word access.
   function automatic size_t decode_size(input logic [2:0] f);
      size_t s;
      unique case (1'b1)
         (f[1:0] == FUNCT3_LB[1:0]): s = SIZE_BYTE;
         (f[1:0] == FUNCT3_LH[1:0]): s = SIZE_HALF;
         default:                    s = SIZE_WORD;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] byte_enable(input size_t s,
                                              input logic [1:0] off);
      logic [3:0] be;
      unique case (s)
         SIZE_BYTE: be = 4'b0001 << off;
         SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         default:   be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] replicate(input size_t s,
                                             input logic [31:0] d);
      logic [31:0] r;
      unique case (s)
         SIZE_BYTE: r = {4{d[7:0]}};
         SIZE_HALF: r = {2{d[15:0]}};
         default:   r = d;
      endcase
      return r;
   endfunction

   function automatic logic misaligned(input size_t s,
                                       input logic [1:0] off);
      logic m;
      unique case (s)
         SIZE_HALF: m = off[0];
         SIZE_WORD: m = (off != 2'b00);
         default:   m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/memory_access_unit_load_formatter.sv
// Load lane select and sign/zero extension for the memory access unit.
module load_formatter
   import memory_access_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  func3,
   output logic [31:0] value
);

   logic [7:0]  b;
   logic [15:0] h;
   logic        uns;

   always_comb begin
      b = word[7:0];
      unique case (offset)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = offset[1] ? word[31:16] : word[15:0];
      uns = func3[2];
      value = word;
      unique case (decode_size(func3))
         SIZE_BYTE: value = {{24{b[7] & ~uns}}, b};
         SIZE_HALF: value = {{16{h[15] & ~uns}}, h};
         default:   value = word;
      endcase
   end

endmodule

// File: rtl/memory_access_unit.sv
// Load/store unit: IDLE -> ACCESS -> DONE bus sequencer with timeout.
// Define MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module memory_access_unit
   import memory_access_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] storeData,
   input  logic [2:0]  func3,
   input  logic        memoryReadEnable,
   input  logic        memoryWriteEnable,
   input  logic        flush,
   output logic        busRequest,
   output logic        busWrite,
   output logic [31:0] busAddress,
   output logic [31:0] busWriteData,
   output logic [3:0]  busByteEnable,
   input  logic        busReady,
   input  logic [31:0] busReadData,
   output logic        stall,
   output logic [31:0] loadData,
   output logic        accessDone,
   output logic        accessFault
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      nxt;
   size_t       size;
   logic        req;
   logic        take;
   logic        trap;
   logic        timeout;
   logic [7:0]  count;
   logic [2:0]  lat_func3;
   logic [1:0]  lat_off;
   logic        fault_q;
   logic [31:0] fmt;

   load_formatter u_fmt (
      .word   (busReadData),
      .offset (lat_off),
      .func3  (lat_func3),
      .value  (fmt)
   );

   // Flush only blocks a request that has not been issued yet.
   always_comb begin
      size = decode_size(func3);
      req = ~reset & (memoryReadEnable | memoryWriteEnable);
      take = ((state == IDLE) & req & ~flush) | ((state == DONE) & req);
`ifdef MISALIGN_TRAP_EN
      trap = take & misaligned(size, address[1:0]);
`else
      trap = 1'b0;
`endif
      timeout = (state == ACCESS) & ~busReady & (count == LIMIT);
   end

   always_comb begin
      nxt = state;
      stall = 1'b0;
      busRequest = 1'b0;
      accessDone = 1'b0;
      accessFault = 1'b0;
      unique case (state)
         IDLE: begin
            stall = take;
            if (take) nxt = trap ? DONE : ACCESS;
         end
         ACCESS: begin
            busRequest = 1'b1;
            stall = 1'b1;
            if (busReady | timeout) nxt = DONE;
         end
         DONE: begin
            accessDone = 1'b1;
            accessFault = fault_q;
            if (take) nxt = trap ? DONE : ACCESS;
            else nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         busWrite <= 1'b0;
         busAddress <= '0;
         busWriteData <= '0;
         busByteEnable <= '0;
         lat_func3 <= '0;
         lat_off <= '0;
         count <= '0;
         fault_q <= 1'b0;
         loadData <= '0;
      end else begin
         state <= nxt;
         if (state == ACCESS) begin
            if (busReady) begin
               loadData <= busWrite ? 32'd0 : fmt;
               fault_q <= 1'b0;
            end else if (timeout) begin
               loadData <= '0;
               fault_q <= 1'b1;
            end else begin
               count <= count + 8'd1;
            end
         end else if (take) begin
            busWrite <= memoryWriteEnable;
            busAddress <= {address[31:2], 2'b00};
            busWriteData <= replicate(size, storeData);
            busByteEnable <= byte_enable(size, address[1:0]);
            lat_func3 <= func3;
            lat_off <= address[1:0];
            count <= '0;
            fault_q <= trap;
            if (trap) loadData <= '0;
         end
      end
   end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed table-driven bench for memory_access_unit.
module tb_memory_access_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] address;
   logic [31:0] storeData;
   logic [2:0]  func3;
   logic        memoryReadEnable;
   logic        memoryWriteEnable;
   logic        flush;
   logic        busRequest;
   logic        busWrite;
   logic [31:0] busAddress;
   logic [31:0] busWriteData;
   logic [3:0]  busByteEnable;
   logic        busReady;
   logic [31:0] busReadData;
   logic        stall;
   logic [31:0] loadData;
   logic        accessDone;
   logic        accessFault;

   int n_cmp = 0;
   int n_bad = 0;

   memory_access_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clock             (clock),
      .reset             (reset),
      .address           (address),
      .storeData         (storeData),
      .func3             (func3),
      .memoryReadEnable  (memoryReadEnable),
      .memoryWriteEnable (memoryWriteEnable),
      .flush             (flush),
      .busRequest        (busRequest),
      .busWrite          (busWrite),
      .busAddress        (busAddress),
      .busWriteData      (busWriteData),
      .busByteEnable     (busByteEnable),
      .busReady          (busReady),
      .busReadData       (busReadData),
      .stall             (stall),
      .loadData          (loadData),
      .accessDone        (accessDone),
      .accessFault       (accessFault)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]  f3;
      logic        re;
      logic        we;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      int          waits;
      logic        ewr;
      logic [31:0] eaddr;
      logic [31:0] ewdata;
      logic [3:0]  ebe;
      logic [31:0] eload;
   } vec_t;

   vec_t v[12];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [2:0] f, input logic re,
                        input logic we, input logic [31:0] a,
                        input logic [31:0] d);
      func3 = f;
      memoryReadEnable = re;
      memoryWriteEnable = we;
      address = a;
      storeData = d;
   endtask

   task automatic idle_inputs();
      memoryReadEnable = 1'b0;
      memoryWriteEnable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      v[0]  = '{3'b000, 1'b1, 1'b0, 32'h103, 32'h0, 32'h80FF_FF11, 0,
                1'b0, 32'h100, 32'h0, 4'b1000, 32'hFFFF_FF80};
      v[1]  = '{3'b101, 1'b1, 1'b0, 32'h202, 32'h0, 32'hBEEF_1234, 1,
                1'b0, 32'h200, 32'h0, 4'b1100, 32'h0000_BEEF};
      v[2]  = '{3'b000, 1'b0, 1'b1, 32'h301, 32'hA5, 32'h0, 0,
                1'b1, 32'h300, 32'hA5A5_A5A5, 4'b0010, 32'h0};
      v[3]  = '{3'b001, 1'b1, 1'b0, 32'h10A, 32'h0, 32'h8001_7FFF, 2,
                1'b0, 32'h108, 32'h0, 4'b1100, 32'hFFFF_8001};
      v[4]  = '{3'b100, 1'b1, 1'b0, 32'h011, 32'h0, 32'h1234_5678, 0,
                1'b0, 32'h010, 32'h0, 4'b0010, 32'h0000_0056};
      v[5]  = '{3'b010, 1'b1, 1'b0, 32'h020, 32'h0, 32'hDEAD_BEEF, 3,
                1'b0, 32'h020, 32'h0, 4'b1111, 32'hDEAD_BEEF};
      v[6]  = '{3'b001, 1'b0, 1'b1, 32'h032, 32'h1234_ABCD, 32'h0, 1,
                1'b1, 32'h030, 32'hABCD_ABCD, 4'b1100, 32'h0};
      v[7]  = '{3'b010, 1'b0, 1'b1, 32'h044, 32'hCAFE_F00D, 32'h0, 0,
                1'b1, 32'h044, 32'hCAFE_F00D, 4'b1111, 32'h0};
      v[8]  = '{3'b111, 1'b1, 1'b0, 32'h050, 32'h0, 32'h1122_3344, 0,
                1'b0, 32'h050, 32'h0, 4'b1111, 32'h1122_3344};
      v[9]  = '{3'b000, 1'b1, 1'b1, 32'h063, 32'h7E, 32'h0, 0,
                1'b1, 32'h060, 32'h7E7E_7E7E, 4'b1000, 32'h0};
      v[10] = '{3'b000, 1'b1, 1'b0, 32'h000, 32'h0, 32'h0000_007F, 0,
                1'b0, 32'h000, 32'h0, 4'b0001, 32'h0000_007F};
      v[11] = '{3'b001, 1'b1, 1'b0, 32'h0E6, 32'h0, 32'h7FFF_0000, 1,
                1'b0, 32'h0E4, 32'h0, 4'b1100, 32'h0000_7FFF};

      reset = 1'b1;
      flush = 1'b0;
      busReady = 1'b0;
      busReadData = '0;
      issue(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      check("rst_busRequest", busRequest, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_loadData", loadData, 32'h0);
      check("rst_accessDone", accessDone, 1'b0);
      check("rst_accessFault", accessFault, 1'b0);
      check("rst_busByteEnable", busByteEnable, 4'h0);
      check("rst_busAddress", busAddress, 32'h0);
      reset = 1'b0;
      tick();

      foreach (v[i]) begin
         issue(v[i].f3, v[i].re, v[i].we, v[i].addr, v[i].sdata);
         #1;
         check("req_stall", stall, 1'b1);
         tick();
         idle_inputs();
         check("acc_busRequest", busRequest, 1'b1);
         check("acc_busWrite", busWrite, v[i].ewr);
         check("acc_busAddress", busAddress, v[i].eaddr);
         check("acc_busByteEnable", busByteEnable, v[i].ebe);
         if (v[i].ewr) check("acc_busWriteData", busWriteData, v[i].ewdata);
         for (int w = 0; w < v[i].waits; w++) tick();
         check("wait_busRequest", busRequest, 1'b1);
         check("wait_busAddress", busAddress, v[i].eaddr);
         busReady = 1'b1;
         busReadData = v[i].rdata;
         #1;
         check("ready_stall", stall, 1'b1);
         tick();
         busReady = 1'b0;
         busReadData = '0;
         check("done_accessDone", accessDone, 1'b1);
         check("done_accessFault", accessFault, 1'b0);
         check("done_stall", stall, 1'b0);
         check("done_loadData", loadData, v[i].eload);
         tick();
         check("post_accessDone", accessDone, 1'b0);
      end

      // Bus never answers: 16 request cycles, then a fault.
      issue(3'b010, 1'b1, 1'b0, 32'h400, 32'h0);
      tick();
      idle_inputs();
      n = 0;
      while (busRequest === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      check("to_request_cycles", n, 16);
      check("to_accessFault", accessFault, 1'b1);
      check("to_loadData", loadData, 32'h0);
      check("to_stall", stall, 1'b0);
      tick();
      check("to_fault_pulse", accessFault, 1'b0);

      // busReady on the final allowed cycle completes normally.
      issue(3'b010, 1'b1, 1'b0, 32'h500, 32'h0);
      tick();
      idle_inputs();
      repeat (15) tick();
      check("edge_busRequest", busRequest, 1'b1);
      busReady = 1'b1;
      busReadData = 32'h0BAD_F00D;
      tick();
      busReady = 1'b0;
      check("edge_accessFault", accessFault, 1'b0);
      check("edge_accessDone", accessDone, 1'b1);
      check("edge_loadData", loadData, 32'h0BAD_F00D);
      tick();

      // Misaligned word load.
      issue(3'b010, 1'b1, 1'b0, 32'h402, 32'h0);
      tick();
      idle_inputs();
`ifdef MISALIGN_TRAP_EN
      check("mis_busRequest", busRequest, 1'b0);
      check("mis_accessFault", accessFault, 1'b1);
      check("mis_loadData", loadData, 32'h0);
      tick();
      check("mis_fault_pulse", accessFault, 1'b0);
`else
      check("mis_busRequest", busRequest, 1'b1);
      check("mis_busAddress", busAddress, 32'h400);
      check("mis_busByteEnable", busByteEnable, 4'b1111);
      busReady = 1'b1;
      busReadData = 32'h0102_0304;
      tick();
      busReady = 1'b0;
      check("mis_loadData", loadData, 32'h0102_0304);
      check("mis_accessFault", accessFault, 1'b0);
      tick();
`endif

      // A new request in DONE goes straight back to ACCESS.
      issue(3'b010, 1'b1, 1'b0, 32'h700, 32'h0);
      tick();
      idle_inputs();
      busReady = 1'b1;
      busReadData = 32'h1111_1111;
      tick();
      busReady = 1'b0;
      issue(3'b010, 1'b1, 1'b0, 32'h704, 32'h0);
      #1;
      check("b2b_done1", accessDone, 1'b1);
      check("b2b_stall", stall, 1'b0);
      tick();
      idle_inputs();
      check("b2b_busRequest", busRequest, 1'b1);
      check("b2b_busAddress", busAddress, 32'h704);
      busReady = 1'b1;
      busReadData = 32'h2222_2222;
      tick();
      busReady = 1'b0;
      check("b2b_loadData", loadData, 32'h2222_2222);
      check("b2b_done2", accessDone, 1'b1);
      tick();

      // Reset in the second ACCESS cycle abandons the transaction.
      issue(3'b010, 1'b1, 1'b0, 32'h800, 32'h0);
      tick();
      idle_inputs();
      tick();
      check("rma_busRequest_before", busRequest, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rma_busRequest", busRequest, 1'b0);
      check("rma_stall", stall, 1'b0);
      check("rma_accessDone", accessDone, 1'b0);
      tick();
      check("rma_accessDone_later", accessDone, 1'b0);
      check("rma_busRequest_later", busRequest, 1'b0);

      // Flush in IDLE suppresses the request.
      issue(3'b010, 1'b1, 1'b0, 32'h900, 32'h0);
      flush = 1'b1;
      #1;
      check("flush_stall", stall, 1'b0);
      tick();
      idle_inputs();
      flush = 1'b0;
      check("flush_busRequest", busRequest, 1'b0);
      tick();
      check("flush_accessDone", accessDone, 1'b0);

      // busReady while idle has no effect.
      busReady = 1'b1;
      tick();
      busReady = 1'b0;
      check("idle_ready_done", accessDone, 1'b0);
      check("idle_ready_req", busRequest, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, bus-wait cycles before the access is abandoned (range 1..255).
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 address  input  32  byte address, taken from the ALU result of the execute/memory register.
REQ-005 storeData  input  32  rs2 value to be stored.
REQ-006 func3  input  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
REQ-007 memoryReadEnable, memoryWriteEnable  input  1 each  load or store request; both high is treated as a store.
REQ-008 flush  input  1  discards a request not yet issued to the bus.
REQ-009 busRequest  output  1  bus transaction valid.
REQ-010 busWrite  output  1  1 = write, 0 = read.
REQ-011 busAddress  output  32  word-aligned address, with bits [1:0] = 00.
REQ-012 busWriteData  output  32  lane-replicated store data.
REQ-013 busByteEnable  output  4  active byte lanes.
REQ-014 busReady  input  1  slave completes the transaction this cycle.
REQ-015 busReadData  input  32  read word, valid when busReady is high.
REQ-016 stall  output  1  holds the upstream pipeline.
REQ-017 loadData  output  32  aligned, extended load result.
REQ-018 accessDone  output  1  one-cycle completion pulse.
REQ-019 accessFault  output  1  one-cycle pulse on a timeout or misaligned access.

Function
REQ-020 FSM states SHALL be: IDLE, ACCESS, DONE.
REQ-021 IDLE with a read or write enable and no flush SHALL:
- latch the address, data, func3 and direction;
- assert stall combinationally;
- go to ACCESS on the next edge.
REQ-022 ACCESS SHALL:
- drive busRequest = 1 together with registered busWrite, busAddress, busByteEnable and busWriteData;
- hold all of these stable until busReady.
REQ-023 ACCESS with busReady SHALL:
- register the formatted load data;
- go to DONE;
- keep stall = 1 in that cycle.
REQ-024 DONE SHALL:
- pulse accessDone;
- keep stall = 0;
- return to IDLE, or go straight to ACCESS if a new request is present.
REQ-025 Minimum latency SHALL be 3 cycles from request to accessDone when busReady arrives in the first ACCESS cycle.
REQ-026 Byte enables SHALL be 0001 shifted by address[1:0] for byte accesses, 0011 shifted by address[1] times 2 for halfword accesses, and 1111 for word accesses.
REQ-027 Store data SHALL be replicated per lane: the byte is copied to all 4 lanes, the halfword to both halves.
REQ-028 Load data SHALL be selected by the latched offset:
- LB and LH sign-extend;
- LBU and LHU zero-extend;
- LW passes the word through.
REQ-029 A timeout counter SHALL clear on entering ACCESS and increment on each ACCESS cycle without busReady.
REQ-030 When the counter reaches TIMEOUT_CYCLES, the unit SHALL:
- drop busRequest;
- pulse accessFault;
- go to DONE with loadData = 0.
REQ-031 busReady in the same cycle as the timeout SHALL win: the access completes normally.
REQ-032 flush in IDLE SHALL suppress the request; flush in ACCESS or DONE SHALL be ignored, so a started bus transaction always completes.
REQ-033 An illegal func3 (011, 110, 111) SHALL be treated as a word access.
REQ-034 busReady outside ACCESS SHALL be ignored.

Reset
REQ-035 Reset SHALL force the state to IDLE and all outputs to 0, including busRequest, stall, loadData, accessDone and accessFault.
REQ-036 Reset mid-ACCESS SHALL abandon the transaction with no completion pulse and drop busRequest on the next edge.

Configuration
REQ-037 With MISALIGN_TRAP_EN defined:
- halfword accesses with address[0] = 1 and word accesses with address[1:0] != 00 SHALL skip the bus;
- the unit SHALL go IDLE -> DONE, pulse accessFault and drive loadData = 0.
REQ-038 Without MISALIGN_TRAP_EN, misaligned offsets SHALL be silently aligned down: address[0] is ignored for halfwords and address[1:0] for words.

Structure
REQ-039 A shared package SHALL hold:
- the FSM state enum;
- func3 constants (FUNCT3_LB ... FUNCT3_LHU, FUNCT3_SB/SH/SW);
- the access-size enum.
REQ-040 The lane-select and extend logic SHALL be a combinational sub-module named load_formatter (inputs: word, offset, func3; output: 32-bit value).

Verification
REQ-041 The bench SHALL cover these directed scenarios:
- LB at 0x103, bus returns 0x80FF_FF11 after 0 wait cycles -> busByteEnable 1000, busAddress 0x100, loadData 0xFFFF_FF80, accessDone on the 3rd cycle.
- LHU at 0x202, bus returns 0xBEEF_1234 -> busByteEnable 1100, loadData 0x0000_BEEF.
- SB of 0x0000_00A5 at 0x301 -> busWrite 1, busByteEnable 0010, busWriteData 0xA5A5_A5A5.
- LW at 0x400 with busReady never asserted and TIMEOUT_CYCLES = 16 -> busRequest high for 16 cycles, then accessFault pulse, loadData 0, stall released.
- LW at 0x402: with MISALIGN_TRAP_EN -> no busRequest and accessFault pulse; without it -> busAddress 0x400.
- Reset asserted in the 2nd ACCESS cycle -> busRequest 0, stall 0, no accessDone; flush in IDLE with memoryReadEnable = 1 -> no busRequest.
